rv32_r_encoder: RTL



---
 rtl/rv32_isa_pkg.sv | 79 +++++++
 rtl/rv32_sync_fifo.sv | 66 ++++++
 rtl/rv32_r_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/rv32_isa_pkg.sv
// ============================================================================
// Module      : rv32_isa_pkg
// Description : RV32I R-type encoding constants, ALU op codes, field types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_isa_pkg;

  localparam logic [6:0] OPCODE_R = 7'b0110011;

  typedef logic [9:0] alu_op_t;

  // Op codes shared with the decoder's alu_op output; code 4 is unassigned.
  localparam alu_op_t ALU_ADD  = 10'd1;
  localparam alu_op_t ALU_SUB  = 10'd2;
  localparam alu_op_t ALU_SLL  = 10'd3;
  localparam alu_op_t ALU_SLT  = 10'd5;
  localparam alu_op_t ALU_SLTU = 10'd6;
  localparam alu_op_t ALU_XOR  = 10'd7;
  localparam alu_op_t ALU_SRL  = 10'd8;
  localparam alu_op_t ALU_SRA  = 10'd9;
  localparam alu_op_t ALU_OR   = 10'd10;
  localparam alu_op_t ALU_AND  = 10'd11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_instr_t;

  typedef struct packed {
    logic       legal;
    logic [6:0] funct7;
    logic [2:0] funct3;
  } funct_sel_t;

  function automatic funct_sel_t alu_decode(input alu_op_t op);
    funct_sel_t s;
    s.legal  = 1'b1;
    s.funct7 = F7_BASE;
    s.funct3 = F3_ADD_SUB;
    case (op)
      ALU_ADD:  s.funct3 = F3_ADD_SUB;
      ALU_SUB:  s.funct7 = F7_ALT;
      ALU_SLL:  s.funct3 = F3_SLL;
      ALU_SLT:  s.funct3 = F3_SLT;
      ALU_SLTU: s.funct3 = F3_SLTU;
      ALU_XOR:  s.funct3 = F3_XOR;
      ALU_SRL:  s.funct3 = F3_SRL_SRA;
      ALU_SRA: begin
        s.funct7 = F7_ALT;
        s.funct3 = F3_SRL_SRA;
      end
      ALU_OR:   s.funct3 = F3_OR;
      ALU_AND:  s.funct3 = F3_AND;
      default:  s.legal  = 1'b0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_sync_fifo.sv
// ============================================================================
// Module      : rv32_sync_fifo
// Description : Synchronous FIFO with flush; DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == C_DEPTH);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rd_data   = r_mem[r_rd_ptr];

  // Storage is reset too, so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32_r_encoder.sv
// ============================================================================
// Module      : rv32_r_encoder
// Description : ALU op + registers -> RV32I R-type word, buffered with address.
//               Optional R_ENCODER_ERR_CNT_EN adds a saturating err_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_r_encoder
  import rv32_isa_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_alu_op,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
`ifdef R_ENCODER_ERR_CNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        err_illegal
);

  funct_sel_t  w_dec;
  r_instr_t    w_instr;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] r_addr;
  logic        r_err;

  assign w_dec   = alu_decode(in_alu_op);
  assign w_instr = '{funct7: w_dec.funct7, rs2: in_rs2, rs1: in_rs1,
                     funct3: w_dec.funct3, rd: in_rd, opcode: OPCODE_R};

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_dec.legal;
  assign w_pop     = out_valid && out_ready;

  rv32_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (w_push),
    .wr_data (w_instr),
    .pop     (w_pop),
    .rd_data (out_instr),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign out_addr    = r_addr;
  assign err_illegal = r_err;

  // r_addr tracks the head slot's address, advancing one word per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else if (flush) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      if (w_pop) r_addr <= r_addr + 32'd4;
      r_err <= w_accept && !w_dec.legal;
    end
  end

`ifdef R_ENCODER_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (flush) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && !w_dec.legal && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire
